// File: rtl/iter_shifter8.sv
// iter_shifter8: multi-cycle 8-bit shift engine.
// It applies a 0-7 position shift (LSL, LSR, ASR, ROL) at up to 3 positions
// per clock. When the shift is finished, it presents the registered result
// with a one-cycle done pulse.
//
// Ports:
//   clk      rising-edge clock
//   reset_n  synchronous active-low reset
//   start    request strobe; accepted only in IDLE or DONE
//   op       00 LSL, 01 LSR, 10 ASR, 11 ROL
//   amt      total shift amount, 0-7
//   d_in     operand
//   busy     high while the engine is shifting
//   done     one-cycle pulse; d_out holds the result
//   d_out    result register (also holds intermediate values while busy)
module iter_shifter8 (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start,
    input  logic [1:0] op,
    input  logic [2:0] amt,
    input  logic [7:0] d_in,
    output logic       busy,
    output logic       done,
    output logic [7:0] d_out
);

    localparam int unsigned WIDTH    = 8;
    localparam int unsigned MAX_STEP = 3;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    localparam logic [1:0] OP_LSL = 2'b00;
    localparam logic [1:0] OP_LSR = 2'b01;
    localparam logic [1:0] OP_ASR = 2'b10;
    localparam logic [1:0] OP_ROL = 2'b11;

    logic [1:0]       state, state_nxt;
    logic [1:0]       op_r, op_nxt;
    logic [2:0]       remaining, remaining_nxt;
    logic [WIDTH-1:0] d_out_nxt;
    logic [1:0]       step;
    logic [WIDTH-1:0] stage_out;
    logic [2*WIDTH-1:0] rol_tmp;

    // Single combinational stage: shift d_out by 0-3 positions under op_r.
    always_comb begin
        rol_tmp   = {d_out, d_out} << step;
        stage_out = d_out;
        case (op_r)
            OP_LSL:  stage_out = d_out << step;
            OP_LSR:  stage_out = d_out >> step;
            OP_ASR:  stage_out = WIDTH'($signed(d_out) >>> step);
            OP_ROL:  stage_out = rol_tmp[2*WIDTH-1:WIDTH];
            default: stage_out = d_out;
        endcase
    end

    // Per-cycle step is min(remaining, MAX_STEP).
    always_comb begin
        if (remaining > 3'(MAX_STEP)) begin
            step = 2'(MAX_STEP);
        end else begin
            step = remaining[1:0];
        end
    end

    // Next-state and datapath update.
    always_comb begin
        state_nxt     = state;
        op_nxt        = op_r;
        remaining_nxt = remaining;
        d_out_nxt     = d_out;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    d_out_nxt     = d_in;
                    op_nxt        = op;
                    remaining_nxt = amt;
                    state_nxt     = (amt == 3'd0) ? DONE : SHIFT;
                end else begin
                    state_nxt = IDLE;
                end
            end
            SHIFT: begin
                d_out_nxt     = stage_out;
                remaining_nxt = remaining - 3'(step);
                if (remaining - 3'(step) == 3'd0) begin
                    state_nxt = DONE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State and datapath registers; busy/done are registered decodes of the next state.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= IDLE;
            op_r      <= 2'b00;
            remaining <= 3'd0;
            d_out     <= 8'h00;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_nxt;
            op_r      <= op_nxt;
            remaining <= remaining_nxt;
            d_out     <= d_out_nxt;
            busy      <= (state_nxt == SHIFT);
            done      <= (state_nxt == DONE);
        end
    end

endmodule

// File: tb/tb_iter_shifter8.sv
module tb_iter_shifter8;

    logic       clk;
    logic       reset_n;
    logic       start;
    logic [1:0] op;
    logic [2:0] amt;
    logic [7:0] d_in;
    logic       busy;
    logic       done;
    logic [7:0] d_out;

    int n_cmp;
    int n_err;

    iter_shifter8 dut (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (start),
        .op      (op),
        .amt     (amt),
        .d_in    (d_in),
        .busy    (busy),
        .done    (done),
        .d_out   (d_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one request, wait (bounded) for done, and check latency and result.
    task automatic run_op(input string tag, input logic [1:0] o, input logic [2:0] a,
                          input logic [7:0] d, input logic [7:0] exp_d, input int exp_lat);
        int cyc;
        int busy_cnt;
        start = 1'b1;
        op    = o;
        amt   = a;
        d_in  = d;
        tick();
        start = 1'b0;
        cyc      = 1;
        busy_cnt = 0;
        while (!done && cyc < 10) begin
            if (busy) busy_cnt++;
            tick();
            cyc++;
        end
        check({tag, "_lat"}, cyc, exp_lat);
        check({tag, "_busy_cycles"}, busy_cnt, exp_lat - 1);
        check({tag, "_dout"}, int'(d_out), int'(exp_d));
        tick();
        check({tag, "_done_pulse"}, int'(done), 0);
        check({tag, "_hold"}, int'(d_out), int'(exp_d));
    endtask

    initial begin
        n_cmp   = 0;
        n_err   = 0;
        reset_n = 1'b0;
        start   = 1'b1;
        op      = 2'b00;
        amt     = 3'd3;
        d_in    = 8'hFF;
        #1;

        // Reset takes priority over a held start.
        tick();
        tick();
        check("rst_dout", int'(d_out), 8'h00);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        reset_n = 1'b1;
        start   = 1'b0;
        tick();
        tick();
        check("idle_busy", int'(busy), 0);
        check("idle_done", int'(done), 0);
        check("idle_dout", int'(d_out), 8'h00);

        // LSL C5 by 7 with intermediate values.
        start = 1'b1; op = 2'b00; amt = 3'd7; d_in = 8'hC5;
        tick();
        start = 1'b0;
        check("lsl7_c1_busy", int'(busy), 1);
        check("lsl7_c1_dout", int'(d_out), 8'hC5);
        tick();
        check("lsl7_c2_dout", int'(d_out), 8'h28);
        check("lsl7_c2_busy", int'(busy), 1);
        tick();
        check("lsl7_c3_dout", int'(d_out), 8'h40);
        check("lsl7_c3_done", int'(done), 0);
        tick();
        check("lsl7_c4_done", int'(done), 1);
        check("lsl7_c4_busy", int'(busy), 0);
        check("lsl7_c4_dout", int'(d_out), 8'h80);
        tick();
        check("lsl7_c5_done", int'(done), 0);

        run_op("lsr5", 2'b01, 3'd5, 8'hC5, 8'h06, 3);
        run_op("asr4", 2'b10, 3'd4, 8'hC5, 8'hFC, 3);
        run_op("rol3", 2'b11, 3'd3, 8'hC5, 8'h2E, 2);
        run_op("amt0", 2'b10, 3'd0, 8'hA5, 8'hA5, 1);
        run_op("asr7", 2'b10, 3'd7, 8'h80, 8'hFF, 4);
        run_op("rol7", 2'b11, 3'd7, 8'h01, 8'h80, 4);
        run_op("lsr1", 2'b01, 3'd1, 8'h81, 8'h40, 2);

        // start during SHIFT is ignored.
        start = 1'b1; op = 2'b01; amt = 3'd5; d_in = 8'hC5;
        tick();
        op = 2'b00; amt = 3'd1; d_in = 8'h00;
        tick();
        start = 1'b0;
        check("ign_c2_busy", int'(busy), 1);
        tick();
        check("ign_c3_done", int'(done), 1);
        check("ign_c3_dout", int'(d_out), 8'h06);
        tick();
        check("ign_c4_done", int'(done), 0);

        // Back-to-back: start accepted in the DONE cycle.
        start = 1'b1; op = 2'b11; amt = 3'd3; d_in = 8'hC5;
        tick();
        start = 1'b0;
        tick();
        check("b2b_c2_done", int'(done), 1);
        check("b2b_c2_dout", int'(d_out), 8'h2E);
        start = 1'b1; op = 2'b00; amt = 3'd1; d_in = 8'h81;
        tick();
        start = 1'b0;
        check("b2b_c3_busy", int'(busy), 1);
        check("b2b_c3_dout", int'(d_out), 8'h81);
        tick();
        check("b2b_c4_done", int'(done), 1);
        check("b2b_c4_dout", int'(d_out), 8'h02);

        // Reset during the second SHIFT cycle aborts the operation.
        tick();
        start = 1'b1; op = 2'b00; amt = 3'd7; d_in = 8'hC5;
        tick();
        start = 1'b0;
        tick();
        check("abort_c2_dout", int'(d_out), 8'h28);
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        check("abort_dout", int'(d_out), 8'h00);
        check("abort_busy", int'(busy), 0);
        check("abort_done", int'(done), 0);
        begin
            int done_seen;
            done_seen = 0;
            for (int i = 0; i < 5; i++) begin
                tick();
                if (done || busy) done_seen++;
            end
            check("abort_quiet", done_seen, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/iter_shifter8.md
Name: iter_shifter8

Overview:
- Multi-cycle 8-bit shift engine for the shifter8 datapath, built around a 2-bit-shamt combinational shift stage (0-3 positions per cycle).
- Accepts a single-cycle start request carrying data, opcode and a 3-bit shift amount (0-7).
- Applies the shift iteratively at no more than 3 positions per clock, then presents a registered result with a one-cycle done pulse.
- Sits between the register file read port and the consumer of shifted data.

Parameters:
- WIDTH, 8, data width; fixed at 8 for this block.
- MAX_STEP, 3, maximum positions shifted per cycle (2-bit stage shamt).

Ports:
- clk  input  1  clock, rising edge.
- reset_n  input  1  synchronous active-low reset.
- start  input  1  request strobe, sampled on the rising edge.
- op  input  2  00 LSL, 01 LSR, 10 ASR, 11 ROL (rotate left).
- amt  input  3  total shift amount, 0-7.
- d_in  input  8  operand.
- busy  output  1  high while state is SHIFT.
- done  output  1  one-cycle pulse; result valid.
- d_out  output  8  result register.

Behaviour:
- Reset
  - When reset_n=0 at a clock edge: state<=IDLE, d_out<=8'h00, busy=0, done=0, remaining<=0, op register<=00.
  - Reset has priority over start and aborts any operation in progress; the partial result is discarded.
- States: IDLE, SHIFT, DONE. busy=(state==SHIFT). done=(state==DONE).
- Start acceptance (edge E0)
  - start is accepted only when state is IDLE or DONE.
  - On acceptance: d_out<=d_in, op_r<=op, remaining<=amt.
  - If amt==0, next state is DONE; otherwise next state is SHIFT.
  - start while in SHIFT is ignored: no effect, no queuing.
- SHIFT
  - Each edge: step=min(remaining,3); d_out<=shift(d_out, op_r, step); remaining<=remaining-step.
  - When remaining-step==0, next state is DONE; otherwise stay in SHIFT.
  - Number of SHIFT cycles is n=ceil(amt/3): amt 1-3 gives 1, 4-6 gives 2, 7 gives 3.
- Shift rules, 8-bit result, bits shifted out are discarded:
  - LSL: zero fill from the LSB.
  - LSR: zero fill from the MSB.
  - ASR: fill with the current bit7 (sign preserved across iterations).
  - ROL: bit7 wraps to bit0.
- Latency: done is high in cycle 1+n after E0.
  - amt=0: done in the cycle right after E0.
  - amt=7: done 4 cycles after E0.
- DONE
  - done=1 for exactly one cycle.
  - If start=1 in that cycle, the new request is accepted (back-to-back operation) and the next state follows the start rules above.
  - Otherwise next state is IDLE.
- Result hold: d_out holds its value in IDLE and DONE until the next accepted start or reset.
- Inputs op, amt and d_in are don't-care except in the accepting cycle.

Test Plan:
- Reset with start held high for 2 cycles -> d_out=00, busy=0, done=0; state remains IDLE after reset_n=1 until start is sampled.
- LSL d_in=C5, amt=7 -> busy for 3 cycles, intermediate d_out 28, 40, then 80; done pulses at E0+4 with d_out=80.
- LSR C5 amt=5 -> d_out=06, done at E0+3. ASR C5 amt=4 -> d_out=FC. ROL C5 amt=3 -> d_out=2E, done at E0+2.
- amt=0, d_in=A5, any op -> done the cycle after E0, d_out=A5, busy never asserted.
- start asserted mid-SHIFT with different d_in -> ignored, original result completes. start held during the DONE cycle -> new operation accepted, no IDLE cycle in between.
- reset_n=0 during the second SHIFT cycle of an amt=7 op -> d_out=00, IDLE next cycle, no done pulse.
